serial_adder: RTL and testbench

Multi-cycle, parametrised adder that computes a WIDTH-bit sum of two operands plus carry-in, DIGIT_W bits per clock, LSB digit first. It generalises the single-bit full adder into a reusable arithmetic block with a start/done handshake, carry-out and signed-overflow flags. It is used where area matters more than latency; the datapath is one DIGIT_W-bit ripple slice reused over WIDTH/DIGIT_W cycles.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/digit_adder.sv | 28 ++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for serial_adder
package serial_adder_pkg;

  // Controller states: IDLE waits for start, RUN adds one digit per cycle,
  // DONE presents the one-cycle result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit slices (and RUN cycles) for one addition.
  function automatic int calc_ndig(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  // Digit counter width; never narrower than one bit so NDIG=1 still works.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT_W-bit ripple-carry slice
module digit_adder #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               ctop
);

  // cv[i] is the carry into bit i of the slice.
  logic [DIGIT_W:0] cv;

  assign cv[0] = cin;

  // One full-adder cell per bit, rippling the carry upward.
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign s[i]    = x[i] ^ y[i] ^ cv[i];
    assign cv[i+1] = (x[i] & y[i]) | (cv[i] & (x[i] ^ y[i]));
  end

  assign cout = cv[DIGIT_W];
  // Carry into the top bit; on the last digit this is the carry into the MSB.
  assign ctop = cv[DIGIT_W-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, optional subtract mode via SERIAL_ADDER_SUB_EN
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT_W);
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (WIDTH < 1 || DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT_W");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT_W-1:0] dig_sum;
  logic               dig_cout;
  logic               dig_ctop;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   b_load;
  logic               cin_load;

  // Subtraction is a + ~b + !carry_in, so only the captured values change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? ~carry_in : carry_in;
`else
  assign b_load   = b;
  assign cin_load = carry_in;
`endif

  digit_adder #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .x   (a_sh[DIGIT_W-1:0]),
    .y   (b_sh[DIGIT_W-1:0]),
    .cin (carry_r),
    .s   (dig_sum),
    .cout(dig_cout),
    .ctop(dig_ctop)
  );

  // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
  if (NDIG == 1) begin : g_acc_single
    assign acc_next = dig_sum;
  end else begin : g_acc_shift
    assign acc_next = {dig_sum, acc[WIDTH-1:DIGIT_W]};
  end

  assign ready     = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN);
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = cout_r;
  assign overflow  = ovf_r;

  // Controller and datapath: accept in IDLE/DONE, one digit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b_load;
            carry_r <= cin_load;
            acc     <= '0;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT_W;
          b_sh    <= b_sh >> DIGIT_W;
          acc     <= acc_next;
          carry_r <= dig_cout;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_DIG) begin
            state  <= DONE;
            done_r <= 1'b1;
            sum_r  <= acc_next;
            cout_r <= dig_cout;
            ovf_r  <= dig_cout ^ dig_ctop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         ready, busy, done, carry_out, overflow;
  logic [W-1:0] sum;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub1 = 1'b0;
`endif
  logic ready1, busy1, done1, sum1, cout1, ovf1;

  serial_adder #(.WIDTH(W), .DIGIT_W(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder #(.WIDTH(1), .DIGIT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1),
    .carry_out(cout1), .overflow(ovf1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input logic s,
                                output logic [W-1:0] rs, output logic rc, output logic ro);
    longint ux, uy, sx, sy, ures, sres;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= (64'sd1 << (W - 1))) ? ux - (64'sd1 << W) : ux;
    sy = (uy >= (64'sd1 << (W - 1))) ? uy - (64'sd1 << W) : uy;
    if (s) begin
      ures = ux - uy - longint'(ci);
      sres = sx - sy - longint'(ci);
      rc   = (ures >= 0);
    end else begin
      ures = ux + uy + longint'(ci);
      sres = sx + sy + longint'(ci);
      rc   = (ures >= (64'sd1 << W));
    end
    rs = ures[W-1:0];
    ro = (sres > (64'sd1 << (W - 1)) - 1) || (sres < -(64'sd1 << (W - 1)));
  endfunction

  task automatic drive_ops(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic s);
    a = x;
    b = y;
    carry_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("subtract requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  // Wait for done (bounded); returns cycles counted after the accepting edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
    int k, n;
    logic [W-1:0] es;
    logic ec, eo;
    k = 0;
    while (!ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".ready"}, ready, 1'b1);
    model(x, y, ci, s, es, ec, eo);
    drive_ops(x, y, ci, s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);
    wait_done(n);
    check({tag, ".latency"}, n, N);
    check({tag, ".sum"}, sum, es);
    check({tag, ".carry_out"}, carry_out, ec);
    check({tag, ".overflow"}, overflow, eo);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".sum_hold"}, sum, es);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] es;
    logic ec, eo;

    repeat (2) @(posedge clk);
    #1;
    check("reset.ready", ready, 1'b1);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.sum", sum, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("carry_wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("signed_ovf", 8'h7F, 8'h01, 1'b0, 1'b0);

    // Reset mid-stream: the previous result must be wiped immediately.
    drive_ops(8'h10, 8'h20, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst.ready", ready, 1'b1);
    check("midrst.busy", busy, 1'b0);
    check("midrst.done", done, 1'b0);
    check("midrst.sum", sum, '0);
    check("midrst.carry_out", carry_out, 1'b0);
    check("midrst.overflow", overflow, 1'b0);
    @(posedge clk); #1;
    check("midrst.no_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0);

    // start pulsed during RUN is ignored and not queued.
    drive_ops(8'h12, 8'h34, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    drive_ops(8'hFF, 8'hFF, 1'b1, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("ignore.latency", n + 2, N);
    check("ignore.sum", sum, 8'h46);
    repeat (2) @(posedge clk);
    #1;
    check("ignore.not_queued", busy, 1'b0);

    // Back-to-back: start held high, second op accepted in the DONE cycle.
    drive_ops(8'h80, 8'h80, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    drive_ops(8'h3C, 8'h0F, 1'b1, 1'b0);
    wait_done(n);
    check("b2b.first_latency", n, N);
    check("b2b.first_sum", sum, 8'h00);
    check("b2b.first_cout", carry_out, 1'b1);
    check("b2b.first_ovf", overflow, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.no_gap", busy, 1'b1);
    wait_done(n);
    check("b2b.second_latency", n, N);
    check("b2b.second_sum", sum, 8'h4C);
    check("b2b.second_cout", carry_out, 1'b0);
    @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 25; i++) begin
      logic s;
      s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      run_op($sformatf("rand%0d", i), W'($urandom_range(0, 255)),
             W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), s);
    end

    // Full-adder truth table on the one-bit instance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int tot;
      v = 3'(i);
      a1 = v[2];
      b1 = v[1];
      cin1 = v[0];
      tot = int'(v[2]) + int'(v[1]) + int'(v[0]);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("fa%0d.latency", i), n, 1);
      check($sformatf("fa%0d.sum", i), sum1, tot % 2);
      check($sformatf("fa%0d.cout", i), cout1, tot / 2);
      @(posedge clk); #1;
    end

    model(8'h00, 8'h00, 1'b0, 1'b0, es, ec, eo);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
